// File: rtl/microsequencer.sv
// Microprogrammed control sequencer: writable microstore plus next-state logic.
// Define MICROSEQ_STACK_EN to enable the CALL/RETURN micro-return stack.
module microsequencer #(
   parameter int              STATE_W       = 7,
   parameter int              SIG_W         = 45,
   parameter int              DEPTH         = 128,
   parameter int              RESET_STATE   = 0,
   parameter int              FETCH_STATE   = 1,
   parameter logic [SIG_W-1:0] RESET_SIGNALS = 45'b001001100000000000000000000001000000000100001,
   parameter int              STACK_DEPTH   = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      stall,
   input  logic [3:0]                cond_in,
   input  logic [STATE_W-1:0]        decode_addr,
   input  logic                      ms_we,
   input  logic [STATE_W-1:0]        ms_waddr,
   input  logic [SIG_W+STATE_W+5:0]  ms_wdata,
   output logic [SIG_W-1:0]          ctrl_signals,
   output logic [STATE_W-1:0]        state,
   output logic                      stack_err
);
   localparam int W = SIG_W + STATE_W + 6;
   localparam logic [STATE_W:0]   DEPTH_L = (STATE_W+1)'(DEPTH);
   localparam logic [STATE_W-1:0] RESET_S = STATE_W'(RESET_STATE);
   localparam logic [STATE_W-1:0] FETCH_S = STATE_W'(FETCH_STATE);

   typedef enum logic [2:0] {
      OP_DISPATCH = 3'b000, OP_FETCH = 3'b001, OP_INCR  = 3'b010, OP_JUMP   = 3'b011,
      OP_CBRANCH  = 3'b100, OP_WAIT  = 3'b101, OP_CALL  = 3'b110, OP_RETURN = 3'b111
   } ns_op_e;

   logic [W-1:0]       r_ms [DEPTH];
   logic [W-1:0]       r_word;
   logic [STATE_W-1:0] r_state;
   logic               r_primed;
   logic               r_stack_err;

   ns_op_e             w_op;
   logic [STATE_W-1:0] w_target;
   logic [1:0]         w_cond_sel;
   logic               w_cond;
   logic [STATE_W:0]   w_inc;
   logic [STATE_W-1:0] w_ret;
   logic [STATE_W:0]   w_raw;
   logic [STATE_W-1:0] w_next;
   logic               w_push;
   logic               w_pop;
   logic               w_err_ev;

   assign w_op       = ns_op_e'(r_word[W-1:W-3]);
   assign w_target   = r_word[SIG_W+STATE_W-1:SIG_W];
   assign w_cond_sel = r_word[SIG_W+STATE_W+1:SIG_W+STATE_W];
   assign w_cond     = cond_in[w_cond_sel] ^ r_word[SIG_W+STATE_W+2];
   assign w_inc      = {1'b0, r_state} + 1'b1;
   assign w_ret      = (w_inc >= DEPTH_L) ? FETCH_S : w_inc[STATE_W-1:0];

`ifdef MICROSEQ_STACK_EN
   localparam int SP_W  = $clog2(STACK_DEPTH + 1);
   localparam int SLOTS = 2 ** SP_W;

   logic [STATE_W-1:0] r_stack [SLOTS];
   logic [SP_W-1:0]    r_sp;
   logic [SP_W-1:0]    w_top;
   logic               w_full;
   logic               w_empty;

   assign w_top   = r_sp - SP_W'(1);
   assign w_full  = (r_sp == SP_W'(STACK_DEPTH));
   assign w_empty = (r_sp == '0);
`else
   logic w_unused_stack_depth;
   assign w_unused_stack_depth = (STACK_DEPTH != 0);
`endif

   always_comb begin
      w_raw    = '0;
      w_push   = 1'b0;
      w_pop    = 1'b0;
      w_err_ev = 1'b0;
      unique case (w_op)
         OP_DISPATCH: w_raw = {1'b0, decode_addr};
         OP_FETCH:    w_raw = {1'b0, FETCH_S};
         OP_INCR:     w_raw = w_inc;
         OP_JUMP:     w_raw = {1'b0, w_target};
         OP_CBRANCH:  w_raw = w_cond ? {1'b0, w_target} : w_inc;
         OP_WAIT:     w_raw = w_cond ? w_inc : {1'b0, r_state};
`ifdef MICROSEQ_STACK_EN
         OP_CALL: begin
            if (w_full) begin
               w_raw    = {1'b0, FETCH_S};
               w_err_ev = 1'b1;
            end else begin
               w_raw  = {1'b0, w_target};
               w_push = 1'b1;
            end
         end
         OP_RETURN: begin
            if (w_empty) begin
               w_raw    = {1'b0, FETCH_S};
               w_err_ev = 1'b1;
            end else begin
               w_raw = {1'b0, r_stack[w_top]};
               w_pop = 1'b1;
            end
         end
`else
         OP_CALL:     w_raw = {1'b0, w_target};
         OP_RETURN:   w_raw = {1'b0, FETCH_S};
`endif
         default:     w_raw = {1'b0, FETCH_S};
      endcase
   end

   assign w_next = (w_raw >= DEPTH_L) ? FETCH_S : w_raw[STATE_W-1:0];

   // Microstore is deliberately outside reset; writes proceed during stall.
   always_ff @(posedge clk) begin
      if (ms_we && ({1'b0, ms_waddr} < DEPTH_L))
         r_ms[ms_waddr] <= ms_wdata;
   end

   // Priming edge loads the word for RESET_STATE without executing its ns_op.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= RESET_S;
         r_word      <= '0;
         r_primed    <= 1'b0;
         r_stack_err <= 1'b0;
      end else if (!stall) begin
         if (!r_primed) begin
            r_word   <= r_ms[RESET_S];
            r_primed <= 1'b1;
         end else begin
            r_state <= w_next;
            r_word  <= r_ms[w_next];
            if (w_err_ev)
               r_stack_err <= 1'b1;
         end
      end
   end

`ifdef MICROSEQ_STACK_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sp <= '0;
      end else if (!stall && r_primed) begin
         if (w_push)
            r_sp <= r_sp + SP_W'(1);
         else if (w_pop)
            r_sp <= w_top;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && !stall && r_primed && w_push)
         r_stack[r_sp] <= w_ret;
   end
`endif

   assign ctrl_signals = r_primed ? r_word[SIG_W-1:0] : RESET_SIGNALS;
   assign state        = r_state;
   assign stack_err    = r_stack_err;

endmodule

// File: tb/tb_microsequencer.sv
// Directed vector bench for microsequencer (DEPTH=100, STACK_DEPTH=2).
module tb_microsequencer;
   localparam int SW = 7;
   localparam int GW = 45;
   localparam int MW = GW + SW + 6;
   localparam logic [GW-1:0] RS = 45'b001001100000000000000000000001000000000100001;

   localparam logic [2:0] DISP = 3'd0, FETCH = 3'd1, INCR = 3'd2, JUMP = 3'd3,
                          CBR = 3'd4, WAITC = 3'd5, CALL = 3'd6, RET = 3'd7;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          stall = 1'b0;
   logic [3:0]    cond_in = '0;
   logic [SW-1:0] decode_addr = '0;
   logic          ms_we = 1'b0;
   logic [SW-1:0] ms_waddr = '0;
   logic [MW-1:0] ms_wdata = '0;
   logic [GW-1:0] ctrl_signals;
   logic [SW-1:0] state;
   logic          stack_err;

   int n_cmp = 0;
   int n_fail = 0;

   microsequencer #(.DEPTH(100), .STACK_DEPTH(2)) dut (
      .clk(clk), .reset(reset), .stall(stall), .cond_in(cond_in),
      .decode_addr(decode_addr), .ms_we(ms_we), .ms_waddr(ms_waddr),
      .ms_wdata(ms_wdata), .ctrl_signals(ctrl_signals), .state(state),
      .stack_err(stack_err)
   );

   always #5 clk = ~clk;

   function automatic logic [GW-1:0] sig_of(int a);
      return ((GW'(a) << 30) | (GW'(a) * GW'(997))) ^ GW'(16'h0F0F);
   endfunction

   function automatic logic [MW-1:0] mw(logic [2:0] op, logic inv, logic [1:0] cs, int tgt, int a);
      return {op, inv, cs, SW'(tgt), sig_of(a)};
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(int a, logic [MW-1:0] d);
      ms_we = 1'b1; ms_waddr = SW'(a); ms_wdata = d;
      tick();
      ms_we = 1'b0;
   endtask

   typedef struct {
      logic       stl;
      logic [3:0] cnd;
      int         dec;
      int         st;
      logic       err;
   } vec_t;

   vec_t tbl[$];

   initial begin
      // program load under reset; unused words default to FETCH
      for (int a = 0; a < 100; a++) wr(a, mw(FETCH, 0, 0, 0, a));
      wr(0,  mw(INCR,  0, 0, 0,  0));
      wr(1,  mw(DISP,  0, 0, 0,  1));
      wr(5,  mw(INCR,  0, 0, 0,  5));
      wr(7,  mw(INCR,  0, 0, 0,  7));
      wr(8,  mw(JUMP,  0, 0, 20, 8));
      wr(20, mw(WAITC, 0, 0, 0,  20));
      wr(21, mw(CBR,   1, 1, 30, 21));
      wr(22, mw(JUMP,  0, 0, 21, 22));
      wr(30, mw(DISP,  0, 0, 0,  30));
      wr(99, mw(INCR,  0, 0, 0,  99));
      wr(10, mw(CALL,  0, 0, 40, 10));
      wr(40, mw(INCR,  0, 0, 0,  40));
      wr(41, mw(CALL,  0, 0, 50, 41));
      wr(50, mw(RET,   0, 0, 0,  50));
      wr(42, mw(RET,   0, 0, 0,  42));
      wr(11, mw(CALL,  0, 0, 60, 11));
      wr(60, mw(CALL,  0, 0, 70, 60));
      wr(70, mw(CALL,  0, 0, 80, 70));

      chk("rst state", 64'(state), 64'd0);
      chk("rst ctrl", 64'(ctrl_signals), 64'(RS));
      chk("rst err", 64'(stack_err), 64'd0);

      reset = 1'b0;
      #1;
      chk("post-rst ctrl", 64'(ctrl_signals), 64'(RS));

      //         stall cond     dec  state err
      tbl.push_back('{1'b0, 4'b0000, 0,   0,  1'b0}); // priming
      tbl.push_back('{1'b0, 4'b0000, 0,   1,  1'b0});
      tbl.push_back('{1'b0, 4'b0000, 7,   7,  1'b0});
      tbl.push_back('{1'b0, 4'b0000, 0,   8,  1'b0});
      tbl.push_back('{1'b0, 4'b0000, 0,   20, 1'b0});
      tbl.push_back('{1'b0, 4'b0000, 0,   20, 1'b0});
      tbl.push_back('{1'b0, 4'b0000, 0,   20, 1'b0});
      tbl.push_back('{1'b0, 4'b0000, 0,   20, 1'b0});
      tbl.push_back('{1'b0, 4'b0001, 0,   21, 1'b0});
      tbl.push_back('{1'b0, 4'b0010, 0,   22, 1'b0});
      tbl.push_back('{1'b0, 4'b0000, 0,   21, 1'b0});
      tbl.push_back('{1'b0, 4'b0000, 0,   30, 1'b0});
      tbl.push_back('{1'b0, 4'b0000, 120, 1,  1'b0});
      tbl.push_back('{1'b0, 4'b0000, 99,  99, 1'b0});
      tbl.push_back('{1'b0, 4'b0000, 0,   1,  1'b0});
      tbl.push_back('{1'b0, 4'b0000, 5,   5,  1'b0});
      tbl.push_back('{1'b1, 4'b0000, 0,   5,  1'b0});
      tbl.push_back('{1'b1, 4'b0000, 0,   5,  1'b0});
      tbl.push_back('{1'b0, 4'b0000, 0,   6,  1'b0});
      tbl.push_back('{1'b0, 4'b0000, 0,   1,  1'b0});
      tbl.push_back('{1'b0, 4'b0000, 10,  10, 1'b0});
      tbl.push_back('{1'b0, 4'b0000, 0,   40, 1'b0});
      tbl.push_back('{1'b0, 4'b0000, 0,   41, 1'b0});
      tbl.push_back('{1'b0, 4'b0000, 0,   50, 1'b0});
`ifdef MICROSEQ_STACK_EN
      tbl.push_back('{1'b0, 4'b0000, 0,   42, 1'b0});
      tbl.push_back('{1'b0, 4'b0000, 0,   11, 1'b0});
      tbl.push_back('{1'b0, 4'b0000, 0,   60, 1'b0});
      tbl.push_back('{1'b0, 4'b0000, 0,   70, 1'b0});
      tbl.push_back('{1'b0, 4'b0000, 0,   1,  1'b1});
      tbl.push_back('{1'b0, 4'b0000, 7,   7,  1'b1});
`else
      tbl.push_back('{1'b0, 4'b0000, 0,   1,  1'b0});
      tbl.push_back('{1'b0, 4'b0000, 11,  11, 1'b0});
      tbl.push_back('{1'b0, 4'b0000, 0,   60, 1'b0});
      tbl.push_back('{1'b0, 4'b0000, 0,   70, 1'b0});
      tbl.push_back('{1'b0, 4'b0000, 0,   80, 1'b0});
      tbl.push_back('{1'b0, 4'b0000, 0,   1,  1'b0});
`endif

      foreach (tbl[i]) begin
         stall       = tbl[i].stl;
         cond_in     = tbl[i].cnd;
         decode_addr = SW'(tbl[i].dec);
         tick();
         chk($sformatf("v%0d state", i), 64'(state), 64'(tbl[i].st));
         chk($sformatf("v%0d ctrl", i), 64'(ctrl_signals), 64'(sig_of(tbl[i].st)));
         chk($sformatf("v%0d err", i), 64'(stack_err), 64'(tbl[i].err));
      end
      stall = 1'b0; cond_in = '0; decode_addr = '0;

      // reset clears sticky error; same-edge write of ms[0] during priming reads old word
      reset = 1'b1;
      #1;
      chk("rst2 state", 64'(state), 64'd0);
      chk("rst2 ctrl", 64'(ctrl_signals), 64'(RS));
      chk("rst2 err", 64'(stack_err), 64'd0);
      reset = 1'b0;
      ms_we = 1'b1; ms_waddr = SW'(0); ms_wdata = mw(INCR, 0, 0, 0, 77);
      tick();
      ms_we = 1'b0;
      chk("prime old state", 64'(state), 64'd0);
      chk("prime old ctrl", 64'(ctrl_signals), 64'(sig_of(0)));
      tick();
      chk("s1 state", 64'(state), 64'd1);
      decode_addr = SW'(5);
      tick();
      chk("s5 state", 64'(state), 64'd5);

      // write during stall lands but held word stays; reset mid-stall
      stall = 1'b1;
      ms_we = 1'b1; ms_waddr = SW'(5); ms_wdata = mw(JUMP, 0, 0, 6, 55);
      tick();
      ms_we = 1'b0;
      chk("stall state", 64'(state), 64'd5);
      chk("stall ctrl", 64'(ctrl_signals), 64'(sig_of(5)));
      reset = 1'b1;
      #1;
      chk("mid-stall rst state", 64'(state), 64'd0);
      chk("mid-stall rst ctrl", 64'(ctrl_signals), 64'(RS));
      #1;
      reset = 1'b0; stall = 1'b0;
      tick();
      chk("prime new ctrl", 64'(ctrl_signals), 64'(sig_of(77)));
      chk("prime new state", 64'(state), 64'd0);
      tick();
      chk("n1 state", 64'(state), 64'd1);
      tick();
      chk("n5 state", 64'(state), 64'd5);
      chk("n5 ctrl", 64'(ctrl_signals), 64'(sig_of(55)));
      decode_addr = '0;
      tick();
      chk("n6 state", 64'(state), 64'd6);
      chk("n6 ctrl", 64'(ctrl_signals), 64'(sig_of(6)));

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/microsequencer.md
# microsequencer

Parametrised microprogrammed control unit for the MIPS datapath: a writable microstore plus next-state sequencer that generates the control-signal word each cycle. It replaces the fixed state-to-signals ROM with a sequencer that does increment, jump, decoded dispatch, conditional branch, wait-on-condition and, optionally, micro-subroutines. It sits between the instruction encoder and the datapath control inputs.

## Interface
- STATE_W, 7, state/address width
- SIG_W, 45, control-signal width
- DEPTH, 128, microstore words (≤ 2^STATE_W)
- RESET_STATE, 0, state after reset
- FETCH_STATE, 1, fallback/fetch state
- RESET_SIGNALS, 45'b001001100000000000000000000001000000000100001, ctrl_signals during reset and the priming cycle
- STACK_DEPTH, 4, micro-return stack entries
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- stall  in  1  hold state and ctrl word
- cond_in  in  4  datapath condition flags (MOC, Z, N, cond-true)
- decode_addr  in  STATE_W  dispatch address from instruction encoder
- ms_we  in  1  microstore write enable
- ms_waddr  in  STATE_W  write address
- ms_wdata  in  SIG_W+STATE_W+6  microword
- ctrl_signals  out  SIG_W  current control word
- state  out  STATE_W  current state
- stack_err  out  1  sticky stack overflow/underflow

## Operation
- Microword W = SIG_W+STATE_W+6: [SIG_W-1:0] signals; [SIG_W+STATE_W-1:SIG_W] target; next two bits cond_sel; next bit inv; [W-1:W-3] ns_op.
- cond = cond_in[cond_sel] ^ inv.
- ns_op: 000 DISPATCH → decode_addr; 001 FETCH → FETCH_STATE; 010 INCR → state+1; 011 JUMP → target; 100 CBRANCH → cond ? target : state+1; 101 WAIT → cond ? state+1 : state; 110 CALL → push state+1, go target; 111 RETURN → pop.
- Range rule: any computed next state ≥ DEPTH (incl. illegal decode_addr, INCR from DEPTH-1) → FETCH_STATE.
- Stack: CALL when full, or RETURN when empty → no push/pop, next = FETCH_STATE, stack_err ← 1 (cleared only by reset).
- Microstore: DEPTH×W array, not cleared by reset; ms_we writes ms_wdata at ms_waddr (addresses ≥ DEPTH ignored).
- Priming: reset sets state=RESET_STATE, primed=0. The first non-stalled edge after reset loads word ← ms[RESET_STATE], primed ← 1, and state stays. Thereafter each non-stalled edge does state ← next and word ← ms[next].
- ctrl_signals = primed ? word[SIG_W-1:0] : RESET_SIGNALS.

## Timing
- Reset (async): state=RESET_STATE, ctrl_signals=RESET_SIGNALS, stack_err=0, stack pointer=0, primed=0.
- One state transition per non-stalled clock; ctrl_signals for a state are valid the whole cycle state shows it (registered read, zero bubble).
- stall=1: state, word, stack, primed hold; stall has priority over every ns_op.
- Same-edge write and read of the same address: the read returns old contents (no bypass).
- Write while stalled takes effect; a held word is not refreshed.
- Reset mid-WAIT/CALL: stack discarded, sequence restarts with priming.

## Configuration
- MICROSEQ_STACK_EN defined: return stack of STACK_DEPTH entries with CALL/RETURN as above.
- Undefined: no stack storage; CALL behaves as JUMP; RETURN behaves as FETCH; stack_err tied 0.

## Test plan
- Reset then release: ctrl_signals=RESET_SIGNALS for 1 cycle, state=0; next cycle ctrl_signals=ms[0] signals; word at 0 = INCR → state 1.
- Dispatch: state 1 word DISPATCH, decode_addr=7 → state 7; decode_addr=120 with DEPTH=100 → state FETCH_STATE (1).
- WAIT on MOC (cond_sel=0, inv=0): cond_in=0000 for 3 cycles → state held 3 cycles; cond_in=0001 → state+1 next edge.
- CBRANCH inv=1 cond_sel=1: Z=1 → state+1; Z=0 → target 30.
- Stack (STACK_DEPTH=2, macro on): CALL 10→40, CALL 41→50, RETURN → 42, RETURN → 11; a 3rd nested CALL → state 1, stack_err=1. Macro off: CALL → target, stack_err stays 0.
- stall=1 for 2 cycles during INCR at state 5 → state 5 and ctrl_signals stable; assert reset mid-stall → state 0, RESET_SIGNALS immediately.
